// File: rtl/sifh_pkg.sv
// Shared constants and readout state encodings for the SiFH histogram readout.
package sifh_pkg;

    localparam int PEAK_MAX  = 8;
    localparam int BIN_NUM   = 64;
    localparam int BIN_W     = 6;
    localparam int PIXEL_NUM = 4;
    localparam int PIX_W     = 2;
    localparam int RAM_ADDR  = PIX_W + BIN_W;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        LAST = 3'd2,
        EMIT = 3'd3,
        FIN  = 3'd4
    } readState_t;

endpackage

// File: rtl/sifh_hist_readout_if.sv
// Peak result stream: valid/ready handshake carrying {pixel, bin, count}.
interface sifh_hist_readout_if;
    import sifh_pkg::*;

    logic                peakValid;
    logic                peakReady;
    logic [PIX_W-1:0]    peakPixel;
    logic [BIN_W-1:0]    peakBin;
    logic [PEAK_MAX-1:0] peakCount;

    modport master (
        output peakValid, peakPixel, peakBin, peakCount,
        input  peakReady
    );

    modport slave (
        input  peakValid, peakPixel, peakBin, peakCount,
        output peakReady
    );

endinterface

// File: rtl/sifh_peak_tracker.sv
// Running maximum over one pixel's bins; ties keep the earliest (lowest) bin.
module sifh_peak_tracker
    import sifh_pkg::*;
(
    input  logic                clk,
    input  logic                res,
    input  logic                first,
    input  logic                valid,
    input  logic [PEAK_MAX-1:0] data,
    input  logic [BIN_W-1:0]    binTag,
    output logic [PEAK_MAX-1:0] maxCount,
    output logic [BIN_W-1:0]    maxBin
);

    // First sample of a pixel reloads the tracker; later samples win only on a strictly larger count.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            maxCount <= '0;
            maxBin   <= '0;
        end else if (valid && (first || (data > maxCount))) begin
            maxCount <= data;
            maxBin   <= first ? '0 : binTag;
        end
    end

endmodule

// File: rtl/sifh_hist_readout.sv
// SiFH histogram readout: scans every bin of every pixel from SRAM port B, streams
// the per-pixel peak, then pulses done.
// Optional build macro SIFH_CLEAR_ON_READ_EN: zero each bin through port A once read.
//
// state | meaning
// IDLE  | waiting for start
// READ  | issuing one bin read per cycle for the current pixel
// LAST  | no read issued; final bin's data is being captured
// EMIT  | peak result held on the stream until accepted
// FIN   | one-cycle done pulse
module sifh_hist_readout
    import sifh_pkg::*;
(
    input  logic                clk,
    input  logic                res,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [RAM_ADDR-1:0] raddr,
    output logic                rEnable,
    input  logic [PEAK_MAX-1:0] counts,
    output logic [RAM_ADDR-1:0] waddr,
    output logic                wEnable,
    output logic [PEAK_MAX-1:0] newCounts,
    sifh_hist_readout_if.master peak
);

    readState_t          state;
    readState_t          stateNext;
    logic [PIX_W-1:0]    pixel;
    logic [BIN_W-1:0]    bin;
    logic                tagValid;
    logic [BIN_W-1:0]    tagBin;
    logic                lastBin;
    logic                lastPixel;
    logic                handshake;
    logic [PEAK_MAX-1:0] maxCount;
    logic [BIN_W-1:0]    maxBin;

    assign lastBin   = (bin == BIN_W'(BIN_NUM - 1));
    assign lastPixel = (pixel == PIX_W'(PIXEL_NUM - 1));
    assign handshake = (state == EMIT) && peak.peakReady;

    // State register.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        stateNext      = state;
        busy           = 1'b0;
        done           = 1'b0;
        rEnable        = 1'b1;
        raddr          = '0;
        peak.peakValid = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) stateNext = READ;
            end
            READ: begin
                busy    = 1'b1;
                rEnable = 1'b0;
                raddr   = {pixel, bin};
                if (lastBin) stateNext = LAST;
            end
            LAST: begin
                busy      = 1'b1;
                stateNext = EMIT;
            end
            EMIT: begin
                busy           = 1'b1;
                peak.peakValid = 1'b1;
                if (handshake) stateNext = lastPixel ? FIN : READ;
            end
            FIN: begin
                done      = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Pixel/bin address counters; the bin counter wraps to 0 naturally after the last bin.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            pixel <= '0;
            bin   <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                pixel <= '0;
                bin   <= '0;
            end
        end else if (state == READ) begin
            bin <= bin + 1'b1;
        end else if (handshake && !lastPixel) begin
            pixel <= pixel + 1'b1;
        end
    end

    // One-cycle delayed tag so each counts word is paired with the bin that produced it.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            tagValid <= 1'b0;
            tagBin   <= '0;
        end else begin
            tagValid <= (state == READ);
            tagBin   <= bin;
        end
    end

    sifh_peak_tracker u_tracker (
        .clk      (clk),
        .res      (res),
        .first    (tagValid && (tagBin == '0)),
        .valid    (tagValid),
        .data     (counts),
        .binTag   (tagBin),
        .maxCount (maxCount),
        .maxBin   (maxBin)
    );

    assign peak.peakPixel = pixel;
    assign peak.peakBin   = maxBin;
    assign peak.peakCount = maxCount;

`ifdef SIFH_CLEAR_ON_READ_EN
    logic [PIX_W-1:0] tagPixel;

    // Pixel half of the delayed tag, used only to address the clear write.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            tagPixel <= '0;
        end else begin
            tagPixel <= pixel;
        end
    end

    // Clear the word whose data is captured this cycle; it has already been read.
    assign wEnable   = tagValid;
    assign waddr     = tagValid ? {tagPixel, tagBin} : '0;
    assign newCounts = '0;
`else
    assign wEnable   = 1'b0;
    assign waddr     = '0;
    assign newCounts = '0;
`endif

endmodule
